// File: rtl/gestor_int_pkg.sv
// gestor_int_pkg: shared definitions for the interrupt controller.
// Holds the FSM state encoding, the register-window offsets and the
// width of the source index reported on int_id and in STATUS.
package gestor_int_pkg;

    localparam int ID_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } estado_t;

    localparam logic [15:0] OFF_MASK    = 16'd0;
    localparam logic [15:0] OFF_PENDING = 16'd1;
    localparam logic [15:0] OFF_STATUS  = 16'd2;

endpackage

// File: rtl/prioridad_int.sv
// prioridad_int: combinational lowest-index priority encoder.
// Bit 0 has the highest priority; o_found is 0 when the vector is empty.
module prioridad_int
    import gestor_int_pkg::*;
#(
    parameter int N_IRQ = 8
) (
    input  logic [N_IRQ-1:0] i_vec,
    output logic             o_found,
    output logic [ID_W-1:0]  o_idx
);

    // Scan from the top down so the last hit, the lowest set index, wins
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_found = 1'b1;
                o_idx   = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/gestor_interrupciones.sv
// gestor_interrupciones: memory-mapped interrupt controller with a
// MASK / PENDING / STATUS register window and an IDLE-REQ-SERVICE
// handshake towards the CPU (int_req / int_ack / int_eoi).
// Optional build macro GESTOR_INT_EDGE_EN: when defined, requests are
// captured on 0->1 transitions of irq_in; otherwise any cycle with
// irq_in high (re)sets the pending bit.
module gestor_interrupciones
    import gestor_int_pkg::*;
#(
    parameter int          N_IRQ     = 8,
    parameter logic [15:0] BASE_ADDR = 16'hFF10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_IRQ-1:0] irq_in,
    input  logic [15:0]      direcciones,
    input  logic [15:0]      datos_w,
    input  logic             we,
    output logic [15:0]      datos_r,
    output logic             int_req,
    output logic [ID_W-1:0]  int_id,
    input  logic             int_ack,
    input  logic             int_eoi
);

    localparam logic [15:0] ADDR_MASK    = BASE_ADDR + OFF_MASK;
    localparam logic [15:0] ADDR_PENDING = BASE_ADDR + OFF_PENDING;
    localparam logic [15:0] ADDR_STATUS  = BASE_ADDR + OFF_STATUS;

    estado_t          r_state;
    estado_t          w_next_state;
    logic [ID_W-1:0]  r_id;
    logic [ID_W-1:0]  w_next_id;
    logic [N_IRQ-1:0] r_mask;
    logic [N_IRQ-1:0] r_pending;

    logic [N_IRQ-1:0] w_capture;
    logic [N_IRQ-1:0] w_eligible;
    logic [N_IRQ-1:0] w_id_onehot;
    logic [N_IRQ-1:0] w_clear;
    logic             w_found;
    logic [ID_W-1:0]  w_winner;
    logic             w_id_ok;
    logic             w_ack_taken;
    logic             w_wr_mask;
    logic             w_wr_pending;
    logic             w_unused_datos;

    // Write-data bits above N_IRQ have no register behind them
    assign w_unused_datos = ^datos_w;

    assign w_wr_mask    = we && (direcciones == ADDR_MASK);
    assign w_wr_pending = we && (direcciones == ADDR_PENDING);

`ifdef GESTOR_INT_EDGE_EN
    logic [N_IRQ-1:0] r_hist;

    // Remember last cycle's request levels so only rising edges capture
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hist <= '0;
        end else begin
            r_hist <= irq_in;
        end
    end

    assign w_capture = irq_in & ~r_hist;
`else
    assign w_capture = irq_in;
`endif

    assign w_eligible = r_pending & r_mask;

    prioridad_int #(
        .N_IRQ (N_IRQ)
    ) u_prioridad (
        .i_vec   (w_eligible),
        .o_found (w_found),
        .o_idx   (w_winner)
    );

    // Decode the latched source index into a bit position of the window
    always_comb begin
        w_id_onehot = '0;
        for (int i = 0; i < N_IRQ; i++) begin
            w_id_onehot[i] = (r_id == ID_W'(i));
        end
    end

    // The latched source is only still worth requesting while it is
    // both pending and enabled
    assign w_id_ok = |(w_eligible & w_id_onehot);

    // Next-state logic: request the winner, service it on ack, and
    // withdraw a request whose source lost its pending or mask bit
    always_comb begin
        w_next_state = r_state;
        w_next_id    = r_id;
        w_ack_taken  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_next_state = ST_REQ;
                    w_next_id    = w_winner;
                end
            end
            ST_REQ: begin
                if (!w_id_ok) begin
                    w_next_state = ST_IDLE;
                end else if (int_ack) begin
                    w_next_state = ST_SERVICE;
                    w_ack_taken  = 1'b1;
                end
            end
            ST_SERVICE: begin
                if (int_eoi) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Clears come from an accepted ack and from write-1-to-clear
    always_comb begin
        w_clear = '0;
        if (w_wr_pending) begin
            w_clear = datos_w[N_IRQ-1:0];
        end
        if (w_ack_taken) begin
            w_clear = w_clear | w_id_onehot;
        end
    end

    // FSM state and latched source index
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_id    <= '0;
        end else begin
            r_state <= w_next_state;
            r_id    <= w_next_id;
        end
    end

    // MASK and PENDING registers; a capture outranks a same-cycle clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mask    <= '0;
            r_pending <= '0;
        end else begin
            if (w_wr_mask) begin
                r_mask <= datos_w[N_IRQ-1:0];
            end
            r_pending <= (r_pending & ~w_clear) | w_capture;
        end
    end

    // Register window read mux; addresses outside the window read 0
    always_comb begin
        datos_r = '0;
        if (direcciones == ADDR_MASK) begin
            datos_r = 16'(r_mask);
        end else if (direcciones == ADDR_PENDING) begin
            datos_r = 16'(r_pending);
        end else if (direcciones == ADDR_STATUS) begin
            datos_r = {10'd0, r_state, r_id};
        end
    end

    assign int_req = (r_state == ST_REQ);
    assign int_id  = r_id;

endmodule

// File: tb/tb_gestor_interrupciones.sv
// tb_gestor_interrupciones: directed scenario tests plus a randomized run
// checked against a behavioural model of the controller.
module tb_gestor_interrupciones;

    localparam int          N    = 8;
    localparam logic [15:0] BASE = 16'hFF10;
    localparam bit   [15:0] NMSK = 16'h00FF;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] irq_in;
    logic [15:0]  direcciones;
    logic [15:0]  datos_w;
    logic         we;
    logic [15:0]  datos_r;
    logic         int_req;
    logic [3:0]   int_id;
    logic         int_ack;
    logic         int_eoi;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    bit [15:0] m_mask, m_pend, m_hist;
    int        m_state;
    int        m_id;

    gestor_interrupciones #(
        .N_IRQ     (N),
        .BASE_ADDR (BASE)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .irq_in      (irq_in),
        .direcciones (direcciones),
        .datos_w     (datos_w),
        .we          (we),
        .datos_r     (datos_r),
        .int_req     (int_req),
        .int_id      (int_id),
        .int_ack     (int_ack),
        .int_eoi     (int_eoi)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [15:0] off, input logic [15:0] d);
        direcciones = BASE + off;
        datos_w     = d;
        we          = 1'b1;
        tick();
        we          = 1'b0;
    endtask

    task automatic rd(input logic [15:0] off, output logic [15:0] v);
        direcciones = BASE + off;
        #1;
        v = datos_r;
    endtask

    task automatic serve();
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        int_eoi = 1'b1;
        tick();
        int_eoi = 1'b0;
    endtask

    task automatic test_reset();
        logic [15:0] v;
        reset = 1'b0; irq_in = '0; we = 1'b0; int_ack = 1'b0; int_eoi = 1'b0;
        direcciones = '0; datos_w = '0;
        tick(); tick();
        n_checks++; if (int_req !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_int_req: got %b expected 0", int_req); end
        n_checks++; if (int_id !== 4'd0) begin n_fail++; $display("[TB] FAIL rst_int_id: got %0d expected 0", int_id); end
        rd(OFF(0), v);
        n_checks++; if (v !== 16'h0000) begin n_fail++; $display("[TB] FAIL rst_mask: got %h expected 0000", v); end
        rd(OFF(1), v);
        n_checks++; if (v !== 16'h0000) begin n_fail++; $display("[TB] FAIL rst_pending: got %h expected 0000", v); end
        rd(OFF(2), v);
        n_checks++; if (v !== 16'h0000) begin n_fail++; $display("[TB] FAIL rst_status: got %h expected 0000", v); end
        reset = 1'b1;
        tick();
        wr(OFF(0), 16'h0001);
        irq_in = 8'h01;
        tick();
        irq_in = '0;
        rd(OFF(1), v);
        n_checks++; if (v !== 16'h0001) begin n_fail++; $display("[TB] FAIL first_pending: got %h expected 0001", v); end
        n_checks++; if (int_req !== 1'b0) begin n_fail++; $display("[TB] FAIL first_req_early: got %b expected 0", int_req); end
        tick();
        n_checks++; if (int_req !== 1'b1 || int_id !== 4'd0) begin n_fail++; $display("[TB] FAIL first_req: got req=%b id=%0d expected req=1 id=0", int_req, int_id); end
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        n_checks++; if (int_req !== 1'b0) begin n_fail++; $display("[TB] FAIL first_ack_req: got %b expected 0", int_req); end
        rd(OFF(1), v);
        n_checks++; if (v !== 16'h0000) begin n_fail++; $display("[TB] FAIL first_ack_pending: got %h expected 0000", v); end
        rd(OFF(2), v);
        n_checks++; if (v !== 16'h0020) begin n_fail++; $display("[TB] FAIL first_service_status: got %h expected 0020", v); end
        int_eoi = 1'b1;
        tick();
        int_eoi = 1'b0;
        rd(OFF(2), v);
        n_checks++; if (v !== 16'h0000) begin n_fail++; $display("[TB] FAIL first_eoi_status: got %h expected 0000", v); end
    endtask

    function automatic logic [15:0] OFF(input int o);
        return 16'(o);
    endfunction

    task automatic test_regs();
        logic [15:0] v;
        wr(OFF(0), 16'hFFFF);
        rd(OFF(0), v);
        n_checks++; if (v !== 16'h00FF) begin n_fail++; $display("[TB] FAIL mask_upper_bits: got %h expected 00FF", v); end
        rd(OFF(3), v);
        n_checks++; if (v !== 16'h0000) begin n_fail++; $display("[TB] FAIL read_past_window: got %h expected 0000", v); end
        rd(16'hFFFF, v);
        n_checks++; if (v !== 16'h0000) begin n_fail++; $display("[TB] FAIL read_below_window: got %h expected 0000", v); end
        wr(OFF(0), 16'h0000);
    endtask

    task automatic test_priority();
        logic [15:0] v;
        wr(OFF(0), 16'h00FF);
        irq_in = 8'b1000_0100;
        tick();
        irq_in = '0;
        rd(OFF(1), v);
        n_checks++; if (v !== 16'h0084) begin n_fail++; $display("[TB] FAIL prio_pending: got %h expected 0084", v); end
        tick();
        n_checks++; if (int_req !== 1'b1 || int_id !== 4'd2) begin n_fail++; $display("[TB] FAIL prio_first: got req=%b id=%0d expected req=1 id=2", int_req, int_id); end
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        rd(OFF(2), v);
        n_checks++; if (v !== 16'h0022) begin n_fail++; $display("[TB] FAIL prio_service_status: got %h expected 0022", v); end
        int_eoi = 1'b1;
        tick();
        int_eoi = 1'b0;
        n_checks++; if (int_req !== 1'b0) begin n_fail++; $display("[TB] FAIL prio_gap: got %b expected 0", int_req); end
        tick();
        n_checks++; if (int_req !== 1'b1 || int_id !== 4'd7) begin n_fail++; $display("[TB] FAIL prio_second: got req=%b id=%0d expected req=1 id=7", int_req, int_id); end
        serve();
        rd(OFF(1), v);
        n_checks++; if (v !== 16'h0000) begin n_fail++; $display("[TB] FAIL prio_drained: got %h expected 0000", v); end
    endtask

    task automatic test_mask();
        logic [15:0] v;
        wr(OFF(0), 16'h0000);
        irq_in = 8'h08;
        tick();
        irq_in = '0;
        tick(); tick();
        n_checks++; if (int_req !== 1'b0) begin n_fail++; $display("[TB] FAIL masked_req: got %b expected 0", int_req); end
        int_ack = 1'b1; int_eoi = 1'b1;
        tick();
        int_ack = 1'b0; int_eoi = 1'b0;
        rd(OFF(1), v);
        n_checks++; if (v !== 16'h0008) begin n_fail++; $display("[TB] FAIL masked_pending: got %h expected 0008", v); end
        rd(OFF(2), v);
        n_checks++; if (v[5:4] !== 2'd0) begin n_fail++; $display("[TB] FAIL stray_ack_state: got %0d expected 0", v[5:4]); end
        wr(OFF(0), 16'h0008);
        n_checks++; if (int_req !== 1'b0) begin n_fail++; $display("[TB] FAIL unmask_edge1: got %b expected 0", int_req); end
        tick();
        n_checks++; if (int_req !== 1'b1 || int_id !== 4'd3) begin n_fail++; $display("[TB] FAIL unmask_edge2: got req=%b id=%0d expected req=1 id=3", int_req, int_id); end
        serve();
    endtask

    task automatic test_collision();
        logic [15:0] v;
        wr(OFF(0), 16'h0002);
        irq_in = 8'h02;
        tick();
        irq_in = '0;
        tick();
        n_checks++; if (int_req !== 1'b1 || int_id !== 4'd1) begin n_fail++; $display("[TB] FAIL coll_req: got req=%b id=%0d expected req=1 id=1", int_req, int_id); end
        irq_in = 8'h02; int_ack = 1'b1;
        tick();
        irq_in = '0; int_ack = 1'b0;
        rd(OFF(1), v);
        n_checks++; if (v !== 16'h0002) begin n_fail++; $display("[TB] FAIL coll_set_wins: got %h expected 0002", v); end
        n_checks++; if (int_req !== 1'b0) begin n_fail++; $display("[TB] FAIL coll_in_service: got %b expected 0", int_req); end
        int_eoi = 1'b1;
        tick();
        int_eoi = 1'b0;
        tick();
        n_checks++; if (int_req !== 1'b1 || int_id !== 4'd1) begin n_fail++; $display("[TB] FAIL coll_rerequest: got req=%b id=%0d expected req=1 id=1", int_req, int_id); end
        serve();
    endtask

    task automatic test_abort();
        logic [15:0] v;
        wr(OFF(0), 16'h0020);
        irq_in = 8'h20;
        tick();
        irq_in = '0;
        tick();
        n_checks++; if (int_req !== 1'b1 || int_id !== 4'd5) begin n_fail++; $display("[TB] FAIL abort_req: got req=%b id=%0d expected req=1 id=5", int_req, int_id); end
        wr(OFF(0), 16'h0000);
        tick();
        n_checks++; if (int_req !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_drop: got %b expected 0", int_req); end
        rd(OFF(2), v);
        n_checks++; if (v[5:4] !== 2'd0) begin n_fail++; $display("[TB] FAIL abort_state: got %0d expected 0", v[5:4]); end
        rd(OFF(1), v);
        n_checks++; if (v !== 16'h0020) begin n_fail++; $display("[TB] FAIL abort_pending: got %h expected 0020", v); end
        wr(OFF(1), 16'h0020);
        rd(OFF(1), v);
        n_checks++; if (v !== 16'h0000) begin n_fail++; $display("[TB] FAIL w1c_pending: got %h expected 0000", v); end
        wr(OFF(0), 16'h0008);
        irq_in = 8'h08;
        tick();
        irq_in = '0;
        tick();
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        rd(OFF(2), v);
        n_checks++; if (v !== 16'h0023) begin n_fail++; $display("[TB] FAIL pre_reset_status: got %h expected 0023", v); end
        reset = 1'b0;
        #1;
        n_checks++; if (int_req !== 1'b0 || int_id !== 4'd0) begin n_fail++; $display("[TB] FAIL async_reset_out: got req=%b id=%0d expected req=0 id=0", int_req, int_id); end
        rd(OFF(2), v);
        n_checks++; if (v !== 16'h0000) begin n_fail++; $display("[TB] FAIL async_reset_status: got %h expected 0000", v); end
        rd(OFF(0), v);
        n_checks++; if (v !== 16'h0000) begin n_fail++; $display("[TB] FAIL async_reset_mask: got %h expected 0000", v); end
        tick();
        reset = 1'b1;
        int_eoi = 1'b1;
        tick();
        int_eoi = 1'b0;
        rd(OFF(2), v);
        n_checks++; if (v !== 16'h0000) begin n_fail++; $display("[TB] FAIL post_reset_eoi: got %h expected 0000", v); end
    endtask

    task automatic test_macro();
        logic [15:0] v;
        int services;
        services = 0;
        wr(OFF(0), 16'h0010);
        irq_in = 8'h10;
        for (int c = 0; c < 20; c++) begin
            if (c == 10) irq_in = '0;
            int_ack = 1'b0;
            int_eoi = 1'b0;
            if (int_req === 1'b1) begin
                int_ack = 1'b1;
                services++;
            end else begin
                rd(OFF(2), v);
                if (v[5:4] == 2'd2) int_eoi = 1'b1;
            end
            tick();
        end
        int_ack = 1'b0;
        int_eoi = 1'b0;
`ifdef GESTOR_INT_EDGE_EN
        n_checks++; if (services !== 1) begin n_fail++; $display("[TB] FAIL edge_services: got %0d expected 1", services); end
`else
        n_checks++; if (services < 2) begin n_fail++; $display("[TB] FAIL level_services: got %0d expected at least 2", services); end
`endif
        rd(OFF(2), v);
        n_checks++; if (v[5:4] !== 2'd0) begin n_fail++; $display("[TB] FAIL macro_final_state: got %0d expected 0", v[5:4]); end
        wr(OFF(0), 16'h0000);
    endtask

    function automatic logic [15:0] model_read(input int off);
        case (off)
            0: return m_mask;
            1: return m_pend;
            2: return 16'((m_state << 4) | m_id);
            default: return 16'h0000;
        endcase
    endfunction

    // Apply one clock edge of the controller's rules to the model
    task automatic model_step();
        bit [15:0] cap, elig, clr;
        int win;
        cap = 16'(irq_in);
`ifdef GESTOR_INT_EDGE_EN
        cap = cap & ~m_hist;
`endif
        elig = m_pend & m_mask;
        win = -1;
        for (int i = 0; i < N; i++) if (elig[i] && win < 0) win = i;
        clr = '0;
        case (m_state)
            0: if (win >= 0) begin m_state = 1; m_id = win; end
            1: if (!elig[m_id]) m_state = 0;
               else if (int_ack) begin m_state = 2; clr[m_id] = 1'b1; end
            default: if (int_eoi) m_state = 0;
        endcase
        if (we && direcciones == BASE + 16'd1) clr = clr | datos_w;
        m_pend = ((m_pend & ~clr) | cap) & NMSK;
        if (we && direcciones == BASE) m_mask = datos_w & NMSK;
        m_hist = 16'(irq_in);
    endtask

    task automatic test_random();
        int off;
        reset = 1'b0; irq_in = '0; we = 1'b0; int_ack = 1'b0; int_eoi = 1'b0;
        tick();
        reset = 1'b1;
        m_mask = '0; m_pend = '0; m_hist = '0; m_state = 0; m_id = 0;
        for (int k = 0; k < 400; k++) begin
            irq_in      = N'($urandom & $urandom & $urandom);
            int_ack     = 1'($urandom_range(0, 1));
            int_eoi     = ($urandom_range(0, 2) == 0);
            we          = ($urandom_range(0, 5) == 0);
            off         = $urandom_range(0, 4);
            direcciones = BASE + 16'(off);
            datos_w     = 16'($urandom);
            #1;
            n_checks++; if (datos_r !== model_read(off)) begin n_fail++; $display("[TB] FAIL rand_read[%0d] off%0d: got %h expected %h", k, off, datos_r, model_read(off)); end
            @(posedge clk);
            model_step();
            #1;
            n_checks++; if (int_req !== (m_state == 1)) begin n_fail++; $display("[TB] FAIL rand_req[%0d]: got %b expected %b", k, int_req, (m_state == 1)); end
            if (m_state != 0) begin
                n_checks++; if (int_id !== 4'(m_id)) begin n_fail++; $display("[TB] FAIL rand_id[%0d]: got %0d expected %0d", k, int_id, m_id); end
            end
        end
        we = 1'b0; int_ack = 1'b0; int_eoi = 1'b0; irq_in = '0;
    endtask

    initial begin
        test_reset();
        test_regs();
        test_priority();
        test_mask();
        test_collision();
        test_abort();
        test_macro();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gestor_interrupciones.md
GESTOR_INTERRUPCIONES -- requirements
Module: gestor_interrupciones

Interface
REQ-001 Parameter N_IRQ, default 8, number of interrupt request lines (1..16).
REQ-002 Parameter BASE_ADDR, default 16'hFF10, base of the memory-mapped register window.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  system clock, rising-edge active.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 irq_in  in  N_IRQ  raw requests from timer and I/O sources (level, held ≥1 cycle).
REQ-007 direcciones  in  16  CPU bus address.
REQ-008 datos_w  in  16  CPU write data.
REQ-009 we  in  1  CPU write strobe, sampled on the clk rising edge.
REQ-010 datos_r  out  16  read data for the addressed register, combinational; 0 outside the window.
REQ-011 int_req  out  1  interrupt request to the CPU.
REQ-012 int_id  out  4  index of the requested or in-service source.
REQ-013 int_ack  in  1  CPU acceptance pulse, one cycle.
REQ-014 int_eoi  in  1  CPU end-of-service pulse, one cycle.

Function
REQ-015 Register map: BASE+0 MASK (R/W, 1 = enabled); BASE+1 PENDING (R, write 1 to clear); BASE+2 STATUS (R: [3:0] int_id, [5:4] state code IDLE=0, REQ=1, SERVICE=2).
REQ-016 A capture event on irq_in[i] SHALL set PENDING[i] on the following edge regardless of MASK[i].
REQ-017 Eligible set = PENDING & MASK; the winner is the lowest eligible index (bit 0 = highest priority).
REQ-018 FSM state IDLE: when the eligible set is non-zero, latch the winner into int_id, assert int_req, and enter REQ on the next edge (one-cycle latency from PENDING set to int_req).
REQ-019 FSM state REQ: int_req stays 1 and int_id stays stable; on int_ack, clear PENDING[int_id], drop int_req, and enter SERVICE.
REQ-020 In REQ, if MASK[int_id] or PENDING[int_id] becomes 0 before int_ack, drop int_req and return to IDLE without servicing.
REQ-021 FSM state SERVICE: no new request is raised; on int_eoi, return to IDLE, and a further eligible source is requested one cycle later.
REQ-022 int_ack outside REQ and int_eoi outside SERVICE SHALL be ignored.
REQ-023 If a capture event and a clear (ack or write-1-to-clear) hit the same bit in the same cycle, the set wins.
REQ-024 PENDING and MASK bits at index ≥ N_IRQ SHALL read 0 and ignore writes.
REQ-025 A MASK write takes effect on the edge after we; the eligibility check uses the updated value.

Reset
REQ-026 While reset=0: MASK=0, PENDING=0, capture history=0, state=IDLE, int_req=0, int_id=0.
REQ-027 Reset asserted in REQ or SERVICE SHALL abandon service immediately; no ack or eoi is required afterwards.

Configuration
REQ-028 Macro GESTOR_INT_EDGE_EN: when defined, a capture event is a 0→1 transition of irq_in[i] (registered history); a held level sets PENDING only once.
REQ-029 Without GESTOR_INT_EDGE_EN: a capture event is irq_in[i]=1 in any cycle (level-sensitive), so PENDING re-sets while the level persists, even after a clear.

Structure
REQ-030 A shared package gestor_int_pkg SHALL hold the state encoding (IDLE, REQ, SERVICE), register offsets (0, 1, 2), and the int_id width.
REQ-031 One sub-module, prioridad_int, SHALL be a combinational lowest-index priority encoder (N_IRQ-wide vector in; found flag and index out).

Verification
REQ-032 Reset test: deassert reset, write MASK=8'h01, pulse irq_in[0] for 1 cycle -> PENDING=1 after 1 edge, int_req=1 and int_id=0 after 2 edges; int_ack -> int_req=0, PENDING=0.
REQ-033 Priority test: MASK=8'hFF, irq_in=8'b1000_0100 in the same cycle -> int_id=2 first; after ack+eoi, int_id=7.
REQ-034 Mask test: MASK=0, pulse irq_in[3] -> no int_req, PENDING=8'h08; write MASK=8'h08 -> int_req on the second edge with int_id=3.
REQ-035 Collision test: irq_in[1] edge in the same cycle as int_ack for id 1 -> PENDING[1]=1 afterwards; after eoi, id 1 is requested again.
REQ-036 Abort test: in REQ for id 5, write MASK=0 -> int_req=0 and state IDLE next cycle; assert reset in SERVICE -> all outputs 0, STATUS=0.
REQ-037 Macro test: hold irq_in[4]=1 for 10 cycles with ack+eoi each time -> exactly 1 service with GESTOR_INT_EDGE_EN, repeated services without it.
